// File: rtl/blur3x3_stream.sv
// blur3x3_stream: streaming 3x3 box blur of a raster 4-bit pixel stream into the pixel buffer.
// Latency: a write is issued 3 register stages after the accepting edge; one write per cycle peak.
// Backpressure: PIX_READY is high only while a frame is running; input gaps give matching write gaps.
//
// Ports: VGA_CLK/RESET (sync, active-high); START begins a frame when idle;
//        PIX_IN/PIX_VALID/PIX_READY source pixel handshake;
//        PB_WA/PB_DATA/PB_WE pixel-buffer write port; BUSY/DONE frame status.
// Option: define BLUR_DIV_ROUND_EN for round-to-nearest (ties up) instead of floor(S/9).
module blur3x3_stream #(
  parameter int IMG_W     = 160,
  parameter int IMG_H     = 120,
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0
) (
  input  logic              VGA_CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [3:0]        PIX_IN,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  output logic [ADDR_W-1:0] PB_WA,
  output logic [3:0]        PB_DATA,
  output logic              PB_WE,
  output logic              BUSY,
  output logic              DONE
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0]     X_LAST     = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST     = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BASE_ADDR + IMG_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_fcnt;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              w_accept;
  logic              w_start;

  // Line buffers: r_lb1 holds row y-1, r_lb2 holds row y-2 at each column.
  logic [3:0]        r_lb1 [IMG_W];
  logic [3:0]        r_lb2 [IMG_W];
  // Window rows: 0 = y-2, 1 = y-1, 2 = y; column 2 is the newest.
  logic [3:0]        r_win [3][3];

  logic              r_v1, r_v2;
  logic              r_lc1, r_lc2;
  logic [7:0]        r_sum;
  logic [7:0]        w_sum;
  logic [7:0]        w_div_in;
  logic [13:0]       w_prod;
  logic [ADDR_W-1:0] r_addr;

  assign w_accept = PIX_VALID && PIX_READY;
  assign w_start  = (r_state == S_IDLE) && START;

  // FSM next state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    PIX_READY   = 1'b0;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        PIX_READY = 1'b1;
        BUSY      = 1'b1;
        if (PIX_VALID && (r_x == X_LAST) && (r_y == Y_LAST)) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        BUSY = 1'b1;
        // Third flush cycle is when the last write is on the output port.
        if (r_fcnt == 2'd2) begin
          DONE        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge VGA_CLK) begin
    if (RESET || (r_state != S_FLUSH)) r_fcnt <= 2'd0;
    else                               r_fcnt <= r_fcnt + 2'd1;
  end

  // Input raster counters
  always_ff @(posedge VGA_CLK) begin
    if (RESET || w_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Line buffers are not reset: a frame only reads rows it has already written.
  always_ff @(posedge VGA_CLK) begin
    if (w_accept) begin
      r_lb2[r_x] <= r_lb1[r_x];
      r_lb1[r_x] <= PIX_IN;
    end
  end

  // Stage 1: window shift
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= 4'd0;
      r_v1  <= 1'b0;
      r_lc1 <= 1'b0;
    end else begin
      r_v1  <= w_accept && (r_x >= XW'(2)) && (r_y >= YW'(2));
      r_lc1 <= (r_x == X_LAST);
      if (w_accept) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb2[r_x];
        r_win[1][2] <= r_lb1[r_x];
        r_win[2][2] <= PIX_IN;
      end
    end
  end

  always_comb begin
    w_sum = 8'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_sum = w_sum + 8'(r_win[r][c]);
  end

  // Stage 2: 9-input sum
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_sum <= 8'd0;
      r_v2  <= 1'b0;
      r_lc2 <= 1'b0;
    end else begin
      r_sum <= w_sum;
      r_v2  <= r_v1;
      r_lc2 <= r_lc1;
    end
  end

  // Divide by 9 as (S*57)>>9; exact floor for S<=135.
`ifdef BLUR_DIV_ROUND_EN
  assign w_div_in = r_sum + 8'd4;
`else
  assign w_div_in = r_sum;
`endif
  assign w_prod = 14'(w_div_in) * 14'd57;

  // Stage 3: divide, register the write; address skips the two border columns at row end.
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      PB_WE   <= 1'b0;
      PB_WA   <= '0;
      PB_DATA <= 4'd0;
      r_addr  <= '0;
    end else begin
      PB_WE <= r_v2;
      if (r_v2) begin
        PB_DATA <= 4'(w_prod >> 9);
        PB_WA   <= r_addr;
      end
      if (w_start)   r_addr <= ADDR_FIRST;
      else if (r_v2) r_addr <= r_addr + (r_lc2 ? ADDR_W'(3) : ADDR_W'(1));
    end
  end

endmodule

// File: tb/tb_blur3x3_stream.sv
// Bench for blur3x3_stream on an 8x6 image: a frame-level reference model predicts every
// pixel-buffer write (cycle, address, data, DONE) from the source image; a compare process
// checks the DUT output port every cycle, and literal buffer contents pin the model.
module tb_blur3x3_stream;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 15;
`ifdef BLUR_DIV_ROUND_EN
  localparam int IMP_EXP = 2;
`else
  localparam int IMP_EXP = 1;
`endif

  logic          clk = 1'b0;
  logic          RESET, START, PIX_VALID;
  logic [3:0]    PIX_IN;
  logic          PIX_READY, PB_WE, BUSY, DONE;
  logic [AW-1:0] PB_WA;
  logic [3:0]    PB_DATA;

  blur3x3_stream #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BASE_ADDR(0)) dut (
    .VGA_CLK(clk), .RESET(RESET), .START(START), .PIX_IN(PIX_IN),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PB_WA(PB_WA),
    .PB_DATA(PB_DATA), .PB_WE(PB_WE), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int addr; int data; bit done; } ev_t;
  ev_t q[$];
  ev_t e;

  int  img [H][W];
  int  pb [64];
  int  checks = 0, errors = 0;
  int  cyc = 0;
  int  wcount, done_wa;
  bit  cmp_en = 0, prev_done = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the 3x3 mean of the source image around (cx,cy).
  function automatic int exp_pix(input int cx, input int cy);
    int s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += img[cy+dy][cx+dx];
`ifdef BLUR_DIV_ROUND_EN
    return (s + 4) / 9;
`else
    return s / 9;
`endif
  endfunction

  // Compare process: the output port must match the model on every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      if (prev_done) chk("busy_after_done", BUSY, 0);
      prev_done = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("pb_we", PB_WE, 1);
        chk("pb_wa", PB_WA, e.addr);
        chk("pb_data", PB_DATA, e.data);
        chk("done_on_write", DONE, e.done);
        prev_done = e.done;
      end else begin
        chk("pb_we_idle", PB_WE, 0);
        chk("done_idle", DONE, 0);
      end
      if (PB_WE === 1'b1) begin
        wcount++;
        if (PB_WA < 64) pb[PB_WA] = PB_DATA;
      end
      if (DONE === 1'b1) done_wa = PB_WA;
    end
  end

  // pattern: 0 uniform 7, 1 impulse 15 at (3,2), 2 all 15, 3 random
  task automatic run_frame(input int pattern, input int gap_pct, input bit start_again,
                           input int reset_after);
    int k = 0, guard = 0;
    bit v;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (pattern)
          0: img[y][x] = 7;
          1: img[y][x] = (x == 3 && y == 2) ? 15 : 0;
          2: img[y][x] = 15;
          default: img[y][x] = $urandom_range(0, 15);
        endcase
    for (int i = 0; i < 64; i++) pb[i] = -1;
    wcount = 0; done_wa = -1;

    PIX_VALID = 0; START = 1;
    @(negedge clk); #1;
    START = 0;
    chk("busy_after_start", BUSY, 1);
    chk("ready_after_start", PIX_READY, 1);

    while (k < W*H && guard < 2000) begin
      if (k == reset_after) begin
        PIX_VALID = 0; RESET = 1;
        q.delete();
        @(negedge clk); #1;
        chk("busy_after_reset", BUSY, 0);
        chk("ready_after_reset", PIX_READY, 0);
        RESET = 0;
        k = wcount;
        repeat (8) begin @(negedge clk); #1; end
        chk("no_writes_after_reset", wcount, k);
        return;
      end
      v = ($urandom_range(0, 99) >= gap_pct);
      PIX_VALID = v;
      PIX_IN = v ? 4'(img[k / W][k % W]) : 4'($urandom_range(0, 15));
      START = start_again && (k == 10);
      if (v && PIX_READY) begin
        if ((k % W) >= 2 && (k / W) >= 2)
          q.push_back('{due: cyc + 3, addr: (k / W - 1) * W + (k % W - 1),
                        data: exp_pix(k % W - 1, k / W - 1), done: (k == W*H-1)});
        k++;
      end
      @(negedge clk); #1;
      guard++;
    end
    PIX_VALID = 0; START = 0;
    if (k < W*H) chk("accept_timeout", k, W*H);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin @(negedge clk); #1; guard++; end
    chk("drain_timeout", q.size(), 0);
    repeat (2) begin @(negedge clk); #1; end
    chk("busy_end", BUSY, 0);
    chk("write_count", wcount, 24);
    chk("done_addr", done_wa, 38);
  endtask

  initial begin
    RESET = 1; START = 0; PIX_VALID = 0; PIX_IN = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", PIX_READY, 0);
    chk("rst_we", PB_WE, 0);
    chk("rst_wa", PB_WA, 0);
    chk("rst_data", PB_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    #1; RESET = 0; cmp_en = 1;

    // Pixel offered without START is never accepted.
    PIX_VALID = 1; PIX_IN = 4'd5;
    repeat (5) begin
      @(negedge clk); #1;
      chk("idle_ready", PIX_READY, 0);
      chk("idle_busy", BUSY, 0);
    end
    PIX_VALID = 0;

    run_frame(0, 0, 0, -1);
    chk("uni_pb9", pb[9], 7);
    chk("uni_pb14", pb[14], 7);
    chk("uni_pb17", pb[17], 7);
    chk("uni_pb38", pb[38], 7);
    chk("uni_border8", pb[8], -1);
    chk("uni_border15", pb[15], -1);
    chk("uni_border16", pb[16], -1);

    run_frame(1, 0, 0, -1);
    chk("imp_pb10", pb[10], IMP_EXP);
    chk("imp_pb19", pb[19], IMP_EXP);
    chk("imp_pb28", pb[28], IMP_EXP);
    chk("imp_pb9", pb[9], 0);
    chk("imp_pb29", pb[29], 0);

    run_frame(2, 50, 0, -1);
    chk("gap_pb25", pb[25], 15);
    chk("gap_pb38", pb[38], 15);

    run_frame(0, 0, 1, -1);
    chk("restart_pb33", pb[33], 7);

    run_frame(3, 20, 0, 20);

    run_frame(0, 0, 0, -1);
    chk("post_reset_pb30", pb[30], 7);

    run_frame(3, 30, 0, -1);
    run_frame(3, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blur3x3_stream.md
# blur3x3_stream

Streaming 3x3 box-blur engine for the pixel-buffer path. It accepts a raster-order stream of 4-bit source pixels and computes the 3x3 mean of every interior pixel in hardware, including the divide-by-9. It writes each result straight into the write port of the dual-port pixel buffer that the VGA controller reads, so the Nios II no longer sums and divides per pixel. It replaces the software sum plus `divide9` path, and it is clocked in the pixel-buffer (VGA) clock domain.

## Interface
- `IMG_W`, 160, image width in pixels (≥3)
- `IMG_H`, 120, image height in pixels (≥3)
- `ADDR_W`, 15, pixel-buffer address width
- `BASE_ADDR`, 0, pixel-buffer address of pixel (0,0)

Ports:
- `VGA_CLK`  in  1  single clock (pixel-buffer clock)
- `RESET`  in  1  synchronous, active-high reset
- `START`  in  1  one-cycle pulse that begins a frame; ignored unless the engine is IDLE
- `PIX_IN`  in  4  source pixel
- `PIX_VALID`  in  1  `PIX_IN` is valid
- `PIX_READY`  out  1  engine accepts a pixel this cycle
- `PB_WA`  out  ADDR_W  pixel-buffer write address
- `PB_DATA`  out  4  blurred pixel
- `PB_WE`  out  1  pixel-buffer write enable
- `BUSY`  out  1  high from START acceptance until the cycle that DONE pulses
- `DONE`  out  1  one-cycle pulse when the frame's last write has issued

## Operation
- States: IDLE → RUN → FLUSH → IDLE.
  - IDLE → RUN: on `START`.
  - RUN → FLUSH: when the pixel at (IMG_W-1, IMG_H-1) is accepted.
  - FLUSH: lasts exactly 3 cycles, then returns to IDLE with `DONE` pulsed in the last FLUSH cycle.
- Acceptance: a pixel is accepted when `PIX_VALID && PIX_READY`. `PIX_READY` is high only in RUN. Input counters x (0..IMG_W-1) and y (0..IMG_H-1) advance only on acceptance; x wraps to 0 and increments y.
- Line buffers:
  - Two line buffers, each IMG_W x 4 bits, hold rows y-1 and y-2.
  - Both are read and written at column x on acceptance.
  - A 3x3 window register shifts one column left per acceptance.
- Output condition: acceptance of (x,y) with x≥2 and y≥2 produces the result for centre (x-1, y-1). Only the interior (IMG_W-2)x(IMG_H-2) pixels are written; border pixels in the buffer are left untouched.
- Arithmetic:
  - The sum of the 9 pixels is 8 bits unsigned (max 135).
  - Quotient = (S·57) >> 9, using a 14-bit product. This equals floor(S/9) for all S in 0..135.
- Write address:
  - The counter is loaded with BASE_ADDR + IMG_W + 1 on START.
  - It increments by 1 after each write, except after the write for centre column IMG_W-2, where it increments by 3. This skips the right and left border pixels.
  - No multiplier is used.
- Reset takes effect from any state, including mid-frame:
  - State returns to IDLE; counters and window clear.
  - In-flight pipeline writes are discarded.
  - Line-buffer contents need not be cleared, because a frame never reads rows it has not written.
- START received while BUSY is ignored; the frame in progress is unaffected.

## Timing
- Reset values: `PIX_READY`=0, `PB_WE`=0, `PB_WA`=0, `PB_DATA`=0, `BUSY`=0, `DONE`=0.
- `PIX_READY` rises the cycle after START is sampled.
- Pipeline is 3 stages: window shift, 9-input sum, divide plus register.
  - `PB_WE`/`PB_WA`/`PB_DATA` are asserted 3 cycles after the accepting edge.
  - They stay valid for one cycle per write.
- Input gaps (`PIX_VALID` low) produce matching gaps in writes. Data and addresses are unaffected.
- `DONE` coincides with the final `PB_WE` cycle; `BUSY` falls on the following cycle.
- Peak throughput is one pixel and one write per cycle.

## Configuration
- `BLUR_DIV_ROUND_EN`
  - Defined: quotient = ((S+4)·57) >> 9 = round-to-nearest of S/9, with ties rounding up (exact for S+4 ≤ 139).
  - Undefined: truncating floor(S/9).
  - Latency and all other behaviour are identical in both modes.

## Test plan
All scenarios use `IMG_W`=8, `IMG_H`=6, `BASE_ADDR`=0 unless stated.
- Reset then idle: all outputs 0, `PIX_READY` low. A pixel presented without START is not accepted.
- Uniform frame of value 7, `PIX_VALID` held high:
  - exactly 24 writes, all data 7;
  - addresses 9–14, 17–22, 25–30, 33–38;
  - one `DONE` pulse, coincident with the write to address 38.
- Impulse of 15 at (3,2), all other pixels 0:
  - addresses {10,11,12,18,19,20,26,27,28} receive 1 (2 with `BLUR_DIV_ROUND_EN`);
  - the other 15 writes are 0.
- All-15 frame with `PIX_VALID` randomly deasserted about 50% of cycles: 24 writes, all data 15, same addresses and order as the uniform-frame case.
- START pulsed again mid-frame: ignored, output identical to an uninterrupted frame.
- `RESET` asserted after 20 pixels are accepted:
  - no writes after reset;
  - `BUSY` is 0 on the cycle after reset;
  - a subsequent START with a uniform-7 frame yields a correct 24-write result.
